btpipe_out_buffer: RTL and testbench

Block-throttled output buffer that sits directly upstream of the block-throttled pipe-out endpoint (address 0xA0). A free-running data source (pattern generator or capture logic) pushes 16-bit words into an internal circular buffer. The block raises `ep_ready` only when a full host block is available, and serves endpoint reads with one-cycle latency. Error counters report dropped writes, empty reads and block-protocol violations back to the host through a wire-out.

---
 rtl/btpipe_out_buffer.sv | 159 +++++++++++++++
 tb/tb_btpipe_out_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/btpipe_out_buffer.sv
// Purpose : circular word buffer that hands data to the block-throttled pipe-out endpoint a whole block at a time.
// Latency : ep_read at edge N puts the word on ep_data after edge N; a write reaches ep_ready after its own edge.
// Backpr. : source sees src_full (writes while full are dropped); the endpoint is gated by ep_ready per block.
//
// Ports:
//   clk, reset_n             - endpoint clock, async active-low reset
//   src_write/src_data       - source push, one 16-bit word per cycle
//   src_full                 - buffer holds 2^DEPTH_LOG2 words (combinational)
//   ep_blockstrobe/ep_read   - endpoint block start and per-word read strobes
//   ep_data/ep_ready         - registered read data and block-available flag
//   occupancy                - current word count
//   ovf_count/unf_count      - saturating dropped-write / empty-read counters
//   proto_err                - sticky flag for reads outside an announced block
//
// Build option: define BTPIPE_BUF_STATS_EN to build ovf_count, unf_count and
// proto_err; without it those outputs are tied to zero.

module btpipe_out_buffer #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  src_write,
  input  logic [15:0]           src_data,
  output logic                  src_full,
  input  logic                  ep_blockstrobe,
  input  logic                  ep_read,
  output logic [15:0]           ep_data,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic [15:0]           ovf_count,
  output logic [15:0]           unf_count,
  output logic                  proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BLK_W = $clog2(BLOCK_WORDS) + 1;
  // One extra bit so "occupancy - blk_left" can be compared without underflow.
  localparam int CMP_W = DEPTH_LOG2 + 2;

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [BLK_W-1:0]    BLK_LOAD  = BLK_W'(BLOCK_WORDS);
  localparam logic [CMP_W-1:0]    BLK_CMP   = CMP_W'(BLOCK_WORDS);

  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   occ_q;
  logic [DEPTH_LOG2:0]   occ_d;
  logic [BLK_W-1:0]      blk_left_q;
  logic [BLK_W-1:0]      blk_left_d;
  logic [15:0]           ep_data_q;
  logic                  ep_ready_q;
  logic                  ep_ready_d;

  logic wr_en;
  logic rd_en;

  // Full is judged on the pre-edge count, so a same-cycle read never frees
  // room for the write; likewise an empty read never returns the same-cycle write.
  assign src_full = (occ_q == DEPTH_CNT);
  assign wr_en    = src_write & ~src_full;
  assign rd_en    = ep_read & (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Words still owed to the announced block. A strobe always reloads,
  // even if it arrives mid-block (that case is flagged as a protocol error).
  always_comb begin
    blk_left_d = blk_left_q;
    if (ep_blockstrobe) begin
      blk_left_d = BLK_LOAD;
    end else if (ep_read && (blk_left_q != '0)) begin
      blk_left_d = blk_left_q - 1'b1;
    end
  end

  // Ready only when a full block exists beyond what the in-flight block
  // has already claimed: occ - blk_left >= BLOCK_WORDS.
  always_comb begin
    ep_ready_d = ({1'b0, occ_d} >= (CMP_W'(blk_left_d) + BLK_CMP));
  end

  // Storage array carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= src_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      blk_left_q <= '0;
      ep_data_q  <= 16'h0000;
      ep_ready_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        ep_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      occ_q      <= occ_d;
      blk_left_q <= blk_left_d;
      ep_ready_q <= ep_ready_d;
    end
  end

  assign ep_data   = ep_data_q;
  assign ep_ready  = ep_ready_q;
  assign occupancy = occ_q;

`ifdef BTPIPE_BUF_STATS_EN
  logic [15:0] ovf_q;
  logic [15:0] unf_q;
  logic        proto_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q   <= 16'h0000;
      unf_q   <= 16'h0000;
      proto_q <= 1'b0;
    end else begin
      if (src_write && src_full && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'h0001;
      end
      if (ep_read && (occ_q == '0) && (unf_q != 16'hFFFF)) begin
        unf_q <= unf_q + 16'h0001;
      end
      // Sticky: read with no block outstanding, or strobe while one is.
      if ((ep_read && (blk_left_q == '0)) ||
          (ep_blockstrobe && (blk_left_q != '0))) begin
        proto_q <= 1'b1;
      end
    end
  end

  assign ovf_count = ovf_q;
  assign unf_count = unf_q;
  assign proto_err = proto_q;
`else
  assign ovf_count = 16'h0000;
  assign unf_count = 16'h0000;
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_btpipe_out_buffer.sv
module tb_btpipe_out_buffer;

`ifdef BTPIPE_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        src_write;
  logic [15:0] src_data;
  logic        src_full;
  logic        ep_blockstrobe;
  logic        ep_read;
  logic [15:0] ep_data;
  logic        ep_ready;
  logic [10:0] occupancy;
  logic [15:0] ovf_count;
  logic [15:0] unf_count;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  btpipe_out_buffer #(.DEPTH_LOG2(10), .BLOCK_WORDS(256)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .src_write      (src_write),
    .src_data       (src_data),
    .src_full       (src_full),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_read        (ep_read),
    .ep_data        (ep_data),
    .ep_ready       (ep_ready),
    .occupancy      (occupancy),
    .ovf_count      (ovf_count),
    .unf_count      (unf_count),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ep_data"},   32'(ep_data),   32'h0);
    chk({tag, "_ep_ready"},  32'(ep_ready),  32'h0);
    chk({tag, "_occ"},       32'(occupancy), 32'h0);
    chk({tag, "_full"},      32'(src_full),  32'h0);
    chk({tag, "_ovf"},       32'(ovf_count), 32'h0);
    chk({tag, "_unf"},       32'(unf_count), 32'h0);
    chk({tag, "_proto"},     32'(proto_err), 32'h0);
  endtask

  initial begin
    reset_n        = 1'b0;
    src_write      = 1'b0;
    src_data       = 16'h0000;
    ep_blockstrobe = 1'b0;
    ep_read        = 1'b0;
    tick();
    tick();
    chk_reset_vals("por");
    reset_n = 1'b1;
    tick();

    // ---- one block: write 256, strobe, read 256 back-to-back ----
    for (int i = 0; i < 256; i++) begin
      src_write = 1'b1;
      src_data  = 16'(i);
      tick();
      if (i == 254) chk("ready_before_256th", 32'(ep_ready), 32'h0);
    end
    src_write = 1'b0;
    chk("ready_after_256th", 32'(ep_ready),  32'h1);
    chk("occ_256",           32'(occupancy), 32'd256);

    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    chk("ready_after_strobe", 32'(ep_ready),  32'h0);
    chk("occ_after_strobe",   32'(occupancy), 32'd256);

    ep_read = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("blk1_data", 32'(ep_data), 32'(i));
    end
    ep_read = 1'b0;
    chk("blk1_occ_end",   32'(occupancy), 32'd0);
    chk("blk1_proto",     32'(proto_err), 32'h0);
    chk("blk1_ready_end", 32'(ep_ready),  32'h0);

    // ---- fill to full across pointer wrap, 5 extra writes dropped ----
    for (int i = 0; i < 1029; i++) begin
      src_write = 1'b1;
      src_data  = (i < 1024) ? 16'(16'h1000 + i) : 16'hDEAD;
      tick();
    end
    src_write = 1'b0;
    chk("ovf_full",  32'(src_full),  32'h1);
    chk("ovf_occ",   32'(occupancy), 32'd1024);
    chk("ovf_count", 32'(ovf_count), STATS ? 32'd5 : 32'd0);
    chk("ovf_ready", 32'(ep_ready),  32'h1);

    for (int b = 0; b < 4; b++) begin
      ep_blockstrobe = 1'b1;
      tick();
      ep_blockstrobe = 1'b0;
      chk("wrap_ready_strobe", 32'(ep_ready), (b < 3) ? 32'h1 : 32'h0);
      ep_read = 1'b1;
      for (int i = 0; i < 256; i++) begin
        tick();
        chk("wrap_data", 32'(ep_data), 32'(16'h1000 + b * 256 + i));
      end
      ep_read = 1'b0;
    end
    chk("wrap_occ_end",  32'(occupancy), 32'd0);
    chk("wrap_full_end", 32'(src_full),  32'h0);
    chk("wrap_proto",    32'(proto_err), 32'h0);

    // ---- three reads from empty with no block announced ----
    ep_read = 1'b1;
    tick();
    tick();
    tick();
    ep_read = 1'b0;
    chk("unf_count", 32'(unf_count), STATS ? 32'd3 : 32'd0);
    chk("unf_proto", 32'(proto_err), STATS ? 32'h1 : 32'h0);
    chk("unf_data",  32'(ep_data),   32'h13FF);
    chk("unf_occ",   32'(occupancy), 32'd0);

    // ---- reset in the middle of a block ----
    for (int i = 0; i < 512; i++) begin
      src_write = 1'b1;
      src_data  = 16'(16'h2000 + i);
      tick();
    end
    src_write = 1'b0;
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    ep_read = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    ep_read = 1'b0;
    chk("mid_data", 32'(ep_data),   32'h2063);
    chk("mid_occ",  32'(occupancy), 32'd412);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    reset_n = 1'b1;
    chk_reset_vals("post_rst");

    for (int i = 0; i < 256; i++) begin
      src_write = 1'b1;
      src_data  = 16'(16'hA000 + i);
      tick();
    end
    src_write = 1'b0;
    chk("rst_ready", 32'(ep_ready), 32'h1);
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    ep_read = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("rst_data", 32'(ep_data), 32'(16'hA000 + i));
    end
    ep_read = 1'b0;
    chk("rst_occ_end", 32'(occupancy), 32'd0);
    chk("rst_proto",   32'(proto_err), 32'h0);

    // ---- simultaneous write and read on an empty buffer ----
    src_write = 1'b1;
    src_data  = 16'hBEEF;
    ep_read   = 1'b1;
    tick();
    src_write = 1'b0;
    ep_read   = 1'b0;
    chk("wr_rd_empty_data", 32'(ep_data),   32'hA0FF);
    chk("wr_rd_empty_occ",  32'(occupancy), 32'd1);
    chk("wr_rd_empty_unf",  32'(unf_count), STATS ? 32'd1 : 32'd0);
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    ep_read = 1'b1;
    tick();
    ep_read = 1'b0;
    chk("late_word_data", 32'(ep_data),   32'hBEEF);
    chk("late_word_occ",  32'(occupancy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
